controle_servos_rampa: RTL
==========================

// Module: controle_servos_rampa
// PURPOSE
//  N-channel servo PWM generator with per-channel slew-rate-limited width ramping.
//  Successor of the single-channel fixed-width servo controller: widths are arbitrary tick
//  counts written over a valid/ready command port, clamped to a safe range and ramped.
//  Sits between the cube-move sequencer (issues commands) and the servo output pins.
// PARAMETERS
//  N_CANAIS  4        number of servo channels
//  PERIODO   1000000  PWM period in clock ticks (20 ms at 50 MHz)
//  LARG_MIN  50000    minimum legal pulse width, ticks (0 deg)
//  LARG_MAX  100000   maximum legal pulse width, ticks (180 deg)
//  LARG_INI  75000    width loaded at reset (neutral)
//  PASSO     2500     max width change per period, ticks; 0 = no ramp (jump to target)
//  W_CNT     $clog2(PERIODO)  derived counter/width bit-width
// PORTS
//  clock        in   1                 system clock
//  reset        in   1                 asynchronous, active-low reset
//  habilita     in   1                 1 = run; 0 = counter held at 0, all pwm low
//  cmd_valid    in   1                 command present
//  cmd_ready    out  1                 block can accept a command this cycle
//  cmd_canal    in   $clog2(N_CANAIS)+1  target channel index
//  cmd_largura  in   W_CNT             requested pulse width, ticks
//  pwm          out  N_CANAIS          servo control outputs
//  ocupado      out  N_CANAIS          bit i = 1 while current width i != target i
//  fim_periodo  out  1                 1-cycle pulse on last tick of each period
//  erro         out  1                 1-cycle pulse: command to channel >= N_CANAIS
// BEHAVIOUR
//  - Reset (async, reset==0): cnt=0; alvo[i]=atual[i]=LARG_INI; pwm=0; ocupado=0;
//    fim_periodo=0; erro=0; cmd_ready=1. Deassertion: run from cnt=0 next edge.
//  - Counter cnt: 0..PERIODO-1, wraps to 0; advances only while habilita=1.
//  - pwm[i] registered: pwm[i] <= habilita & (cnt < atual[i]); 1-cycle latency vs cnt.
//  - fim_periodo registered pulse when cnt==PERIODO-1 and habilita=1.
//  - Handshake: transfer when cmd_valid & cmd_ready. cmd_ready = 0 only in cycle
//    cnt==PERIODO-1 (update cycle); a held cmd_valid is accepted the next cycle.
//  - Accepted cmd, cmd_canal < N_CANAIS: alvo[canal] <= clamp(cmd_largura,LARG_MIN,LARG_MAX).
//    Repeated writes: last accepted wins. Width changes only atual, never mid-period.
//  - Accepted cmd, cmd_canal >= N_CANAIS: consumed, no state change, erro=1 next cycle.
//  - Ramp update, cycle cnt==PERIODO-1 (habilita=1), every channel in parallel:
//    d = alvo-atual; |d|<=PASSO or PASSO==0 -> atual=alvo; else atual +/- PASSO.
//    New atual is used from next cnt==0: no runt/glitch pulses.
//  - ocupado[i] = (atual[i] != alvo[i]), registered, reflects state after each update.
//  - habilita=0: cnt reset to 0, pwm=0, no ramp steps; commands still accepted.
//  - Width arithmetic: W_CNT+1 bits signed for d; clamp before storing; no overflow.
// STRUCTURE
//  - Package servo_pkg: PERIODO/LARG_MIN/LARG_MAX/LARG_INI/PASSO defaults, clamp function.
//  - Sub-module rampa_canal (one per channel, generate loop): holds alvo/atual,
//    clamp, step logic, ocupado; inputs wr_en, largura, atualiza.
//  - Top: period counter, handshake/decode, pwm comparators, fim_periodo, erro.
// TESTING  (bench params: N_CANAIS=4 PERIODO=200 LARG_MIN=10 LARG_MAX=20 LARG_INI=15 PASSO=2)
//  1 Reset, habilita=1 -> every pwm high 15 cycles per 200; ocupado=0; cmd_ready=1.
//  2 cmd ch1 width 20 -> ocupado[1]=1; pwm[1] widths 17,19,20 next periods; ocupado[1]=0 after.
//  3 cmd ch2 width 3 -> target 10 (15,13,11,10); cmd ch2 width 50 -> target 20.
//  4 cmd ch 5 -> erro pulses 1 cycle; all targets/widths unchanged.
//  5 cmd_valid held from cnt==199 -> cmd_ready=0 there; accepted at cnt==0.
//  6 reset low mid-ramp -> pwm=0, ocupado=0 immediately; after release widths 15.
//  7 habilita=0 for 3 periods -> pwm low, no ramp progress; resumes from cnt=0.

Source files
------------

// File: rtl/controle_servos_rampa_pkg.sv
// rtl/controle_servos_rampa_pkg.sv - servo ramp defaults and width clamp helper
package servo_pkg;

    localparam int N_CANAIS_DEF = 4;
    localparam int PERIODO_DEF  = 1000000;
    localparam int LARG_MIN_DEF = 50000;
    localparam int LARG_MAX_DEF = 100000;
    localparam int LARG_INI_DEF = 75000;
    localparam int PASSO_DEF    = 2500;

    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/controle_servos_rampa_if.sv
// rtl/controle_servos_rampa_if.sv - width command port (valid/ready)
interface controle_servos_rampa_if #(
    parameter int N_CANAIS = 4,
    parameter int W_CNT    = 20
);
    import servo_pkg::*;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [$clog2(N_CANAIS):0] cmd_canal;
    logic [W_CNT-1:0]          cmd_largura;

    modport master (output cmd_valid, output cmd_canal, output cmd_largura, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_canal, input cmd_largura, output cmd_ready);

endinterface

// File: rtl/controle_servos_rampa_canal.sv
// rtl/controle_servos_rampa_canal.sv - one channel: clamped target, slew-limited width
module rampa_canal
    import servo_pkg::*;
#(
    parameter int W_CNT    = 20,
    parameter int LARG_MIN = LARG_MIN_DEF,
    parameter int LARG_MAX = LARG_MAX_DEF,
    parameter int LARG_INI = LARG_INI_DEF,
    parameter int PASSO    = PASSO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [W_CNT-1:0] largura,
    input  logic             atualiza,
    output logic [W_CNT-1:0] atual,
    output logic             ocupado
);

    localparam logic [W_CNT:0]   PASSO_MAG = (W_CNT+1)'(PASSO);
    localparam logic [W_CNT-1:0] PASSO_W   = W_CNT'(PASSO);

    logic [W_CNT-1:0]   alvo;
    logic [W_CNT-1:0]   alvo_n;
    logic [W_CNT-1:0]   atual_n;
    logic signed [W_CNT:0] d;
    logic [W_CNT:0]     mag;

    // Extra bit keeps the difference signed without overflow for any pair of widths.
    always_comb begin
        d       = $signed({1'b0, alvo}) - $signed({1'b0, atual});
        mag     = d[W_CNT] ? $unsigned(-d) : $unsigned(d);
        alvo_n  = alvo;
        atual_n = atual;
        if (wr_en)
            alvo_n = W_CNT'(clamp(32'(largura), 32'(LARG_MIN), 32'(LARG_MAX)));
        if (atualiza) begin
            if (PASSO == 0 || mag <= PASSO_MAG)
                atual_n = alvo;
            else if (d[W_CNT])
                atual_n = atual - PASSO_W;
            else
                atual_n = atual + PASSO_W;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alvo    <= W_CNT'(LARG_INI);
            atual   <= W_CNT'(LARG_INI);
            ocupado <= 1'b0;
        end else begin
            alvo    <= alvo_n;
            atual   <= atual_n;
            ocupado <= (atual_n != alvo_n);
        end
    end

endmodule

// File: rtl/controle_servos_rampa.sv
// rtl/controle_servos_rampa.sv - N-channel servo PWM with per-channel ramped widths
module controle_servos_rampa
    import servo_pkg::*;
#(
    parameter int N_CANAIS = N_CANAIS_DEF,
    parameter int PERIODO  = PERIODO_DEF,
    parameter int LARG_MIN = LARG_MIN_DEF,
    parameter int LARG_MAX = LARG_MAX_DEF,
    parameter int LARG_INI = LARG_INI_DEF,
    parameter int PASSO    = PASSO_DEF,
    parameter int W_CNT    = $clog2(PERIODO)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 habilita,
    controle_servos_rampa_if.slave cmd,
    output logic [N_CANAIS-1:0]  pwm,
    output logic [N_CANAIS-1:0]  ocupado,
    output logic                 fim_periodo,
    output logic                 erro
);

    localparam int CW = $clog2(N_CANAIS) + 1;

    logic [W_CNT-1:0]    cnt;
    logic                ultimo;
    logic                aceita;
    logic                canal_ok;
    logic                atualiza;
    logic [N_CANAIS-1:0] wr_en;
    logic [W_CNT-1:0]    atual [N_CANAIS];

    assign ultimo        = (cnt == W_CNT'(PERIODO - 1));
    assign atualiza      = habilita & ultimo;
    // Commands are refused only in the update cycle so a write never races a ramp step.
    assign cmd.cmd_ready = ~ultimo;
    assign aceita        = cmd.cmd_valid & cmd.cmd_ready;
    assign canal_ok      = (cmd.cmd_canal < CW'(N_CANAIS));

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_CANAIS; i++)
            wr_en[i] = aceita & (cmd.cmd_canal == CW'(i));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!habilita || ultimo)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < N_CANAIS; g++) begin : g_canal
            rampa_canal #(
                .W_CNT   (W_CNT),
                .LARG_MIN(LARG_MIN),
                .LARG_MAX(LARG_MAX),
                .LARG_INI(LARG_INI),
                .PASSO   (PASSO)
            ) u_canal (
                .clock   (clock),
                .reset   (reset),
                .wr_en   (wr_en[g]),
                .largura (cmd.cmd_largura),
                .atualiza(atualiza),
                .atual   (atual[g]),
                .ocupado (ocupado[g])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm         <= '0;
            fim_periodo <= 1'b0;
            erro        <= 1'b0;
        end else begin
            for (int i = 0; i < N_CANAIS; i++)
                pwm[i] <= habilita & (cnt < atual[i]);
            fim_periodo <= atualiza;
            erro        <= aceita & ~canal_ok;
        end
    end

endmodule
